// File: rtl/axi_vdma_pkg.sv
// Shared types and constants for the AXI write burst sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_vdma_pkg;

  // Sequencer control states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CALC      = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FIN       = 3'd4
  } state_e;

  // AXI bursts must never straddle a 4 KB page
  localparam logic [12:0] BOUNDARY_4K = 13'h1000;

endpackage

// File: rtl/burst_len_calc.sv
// Burst length = min(remaining beats, MAX_BURST, beats left before the next 4 KB page).
// Latency: combinational; the parent registers the result.
// Backpressure: none (pure function of its inputs).
module burst_len_calc
  import axi_vdma_pkg::*;
#(
  parameter int TSIZE      = 24,
  parameter int LSIZE      = 10,
  parameter int MAX_BURST  = 256,
  parameter int BEAT_BYTES = 32
) (
  input  logic [TSIZE-1:0] remaining,
  input  logic [11:0]      addr_lo,
  output logic [LSIZE-1:0] len
);

  localparam int OFF_W = $clog2(BEAT_BYTES);

  logic [12:0]      bytes_to_4k;
  logic [12:0]      beats_to_4k;
  logic [TSIZE-1:0] cap;

  // addr_lo is beat aligned, so the page remainder divides evenly into beats
  always_comb begin
    bytes_to_4k = BOUNDARY_4K - {1'b0, addr_lo};
    beats_to_4k = bytes_to_4k >> OFF_W;
    cap         = TSIZE'(MAX_BURST);
    if (TSIZE'(beats_to_4k) < cap) cap = TSIZE'(beats_to_4k);
    if (remaining < cap)           cap = remaining;
    len = LSIZE'(cap);
  end

endmodule

// File: rtl/axi_wr_burst_sequencer.sv
// Splits a write transfer into AXI bursts (<= MAX_BURST beats, never crossing 4 KB).
// Latency: start -> first write_req 2 cycles; req_done -> next write_req 2 cycles.
// Backpressure: write_req held until req_resp; next burst waits for req_done.
module axi_wr_burst_sequencer
  import axi_vdma_pkg::*;
#(
  parameter int ASIZE      = 32,
  parameter int LSIZE      = 10,
  parameter int TSIZE      = 24,
  parameter int MAX_BURST  = 256,
  parameter int BEAT_BYTES = 32
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             start,
  input  logic [ASIZE-1:0] xfer_addr,
  input  logic [TSIZE-1:0] xfer_beats,
  output logic             busy,
  output logic             xfer_done,
  output logic [15:0]      burst_cnt,
  output logic             write_req,
  output logic [LSIZE-1:0] req_len,
  output logic [ASIZE-1:0] req_addr,
  input  logic             req_resp,
  input  logic             req_done
);

  localparam int OFF_W = $clog2(BEAT_BYTES);

  state_e           state_q, state_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [TSIZE-1:0] rem_q, rem_d;
  logic [ASIZE-1:0] req_addr_q, req_addr_d;
  logic [LSIZE-1:0] req_len_q, req_len_d;
  logic [15:0]      burst_cnt_q, burst_cnt_d;
  logic [LSIZE-1:0] calc_len;
  logic [TSIZE-1:0] rem_after;
  logic             burst_fin;

  burst_len_calc #(
    .TSIZE     (TSIZE),
    .LSIZE     (LSIZE),
    .MAX_BURST (MAX_BURST),
    .BEAT_BYTES(BEAT_BYTES)
  ) u_len_calc (
    .remaining(rem_q),
    .addr_lo  (addr_q[11:0]),
    .len      (calc_len)
  );

  // A done seen while still requesting implies the core already took the request
  assign burst_fin = req_done && ((state_q == ST_REQ) || (state_q == ST_WAIT_DONE));
  assign rem_after = rem_q - TSIZE'(req_len_q);

  // Next-state and datapath updates; req_len/req_addr only change in CALC
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = xfer_addr & ~ASIZE'(BEAT_BYTES - 1);
          rem_d       = xfer_beats;
          burst_cnt_d = 16'd0;
          state_d     = (xfer_beats == '0) ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        req_len_d  = calc_len;
        req_addr_d = addr_q;
        state_d    = ST_REQ;
      end
      ST_REQ: begin
        if (req_resp) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        state_d = ST_WAIT_DONE;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (burst_fin) begin
      addr_d      = addr_q + (ASIZE'(req_len_q) << OFF_W);
      rem_d       = rem_after;
      burst_cnt_d = (burst_cnt_q == 16'hFFFF) ? burst_cnt_q : burst_cnt_q + 16'd1;
      state_d     = (rem_after == '0) ? ST_FIN : ST_CALC;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign busy      = (state_q == ST_CALC) || (state_q == ST_REQ) || (state_q == ST_WAIT_DONE);
  assign xfer_done = (state_q == ST_FIN);
  assign write_req = (state_q == ST_REQ);
  assign req_len   = req_len_q;
  assign req_addr  = req_addr_q;
  assign burst_cnt = burst_cnt_q;

endmodule
